// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: TDM link input stream and demultiplexed frame outputs.
interface tdm_demux4_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic frame_sync;
  logic [WIDTH-1:0] ch0, ch1, ch2, ch3;
  logic frame_valid;
  logic locked;
  logic sync_err;
  logic [1:0] slot;
  modport master (
    output din, din_valid, frame_sync,
    input ch0, ch1, ch2, ch3, frame_valid, locked, sync_err, slot
  );
  modport slave (
    input din, din_valid, frame_sync,
    output ch0, ch1, ch2, ch3, frame_valid, locked, sync_err, slot
  );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: 1-to-4 TDM demultiplexer with frame-sync alignment and atomic frame update.
module tdm_demux4 #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  tdm_demux4_if.slave bus
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state, state_nx;
  logic [1:0] slot_q, slot_nx;
  logic [WIDTH-1:0] s0, s1, s2, c0, c1, c2, c3;
  logic fv, se, acc, fs, lk, fill;
  assign acc = bus.din_valid;
  assign fs = acc & bus.frame_sync;
  assign lk = state == LOCKED;
  // Any non-sync word in a locked frame is data for the current slot, except slot 0 (missing sync).
  assign fill = lk & acc & ~bus.frame_sync & (slot_q != 2'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      slot_q <= 2'd0;
    end else begin
      state <= state_nx;
      slot_q <= slot_nx;
    end
  always_comb begin
    state_nx = state;
    slot_nx = slot_q;
    if (fs) begin
      state_nx = LOCKED;
      slot_nx = 2'd1;
    end else if (acc && lk) begin
      state_nx = slot_q == 2'd0 ? HUNT : LOCKED;
      slot_nx = slot_q == 2'd0 ? 2'd0 : slot_q + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
      fv <= 1'b0;
      se <= 1'b0;
    end else begin
      if (fs) s0 <= bus.din;
      if (fill && slot_q == 2'd1) s1 <= bus.din;
      if (fill && slot_q == 2'd2) s2 <= bus.din;
      if (fill && slot_q == 2'd3) begin
        c0 <= s0;
        c1 <= s1;
        c2 <= s2;
        c3 <= bus.din;
      end
      fv <= fill && slot_q == 2'd3;
      se <= lk & acc & (bus.frame_sync ? slot_q != 2'd0 : slot_q == 2'd0);
    end
  always_comb begin
    bus.ch0 = c0;
    bus.ch1 = c1;
    bus.ch2 = c2;
    bus.ch3 = c3;
    bus.frame_valid = fv;
    bus.sync_err = se;
    bus.locked = lk;
    bus.slot = slot_q;
  end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed and random TDM streams checked against a frame-queue reference model.
module tb_tdm_demux4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  tdm_demux4_if #(32) bus();
  tdm_demux4_if #(1) bus1();
  assign bus1.din = bus.din[0];
  assign bus1.din_valid = bus.din_valid;
  assign bus1.frame_sync = bus.frame_sync;
  tdm_demux4 #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  tdm_demux4 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;
  logic [31:0] q[$];
  logic [31:0] m_ch[4];
  bit m_lk, e_fv, e_se;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_lk = 0;
    q.delete();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    e_fv = 0;
    e_se = 0;
  endtask
  task automatic check_all();
    chk("frame_valid", bus.frame_valid, e_fv);
    chk("sync_err", bus.sync_err, e_se);
    chk("locked", bus.locked, m_lk);
    if (m_lk) chk("slot", bus.slot, q.size());
    chk("ch0", bus.ch0, m_ch[0]);
    chk("ch1", bus.ch1, m_ch[1]);
    chk("ch2", bus.ch2, m_ch[2]);
    chk("ch3", bus.ch3, m_ch[3]);
    chk("w1_ch0", bus1.ch0, m_ch[0][0]);
    chk("w1_ch1", bus1.ch1, m_ch[1][0]);
    chk("w1_ch2", bus1.ch2, m_ch[2][0]);
    chk("w1_ch3", bus1.ch3, m_ch[3][0]);
    chk("w1_fv", bus1.frame_valid, e_fv);
    chk("w1_se", bus1.sync_err, e_se);
  endtask
  // Model: a frame is the list of words since the last sync; four words complete it.
  task automatic apply(input bit v, input bit f, input logic [31:0] d);
    bus.din = d;
    bus.din_valid = v;
    bus.frame_sync = f;
    @(posedge clk);
    e_fv = 0;
    e_se = 0;
    if (v) begin
      if (!m_lk) begin
        if (f) begin
          m_lk = 1;
          q = {d};
        end
      end else if (f) begin
        e_se = q.size() != 0;
        q = {d};
      end else if (q.size() == 0) begin
        e_se = 1;
        m_lk = 0;
      end else begin
        q.push_back(d);
        if (q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_ch[i] = q[i];
          e_fv = 1;
          q.delete();
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask
  task automatic frame4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    apply(1, 1, a);
    apply(1, 0, b);
    apply(1, 0, c);
    apply(1, 0, d);
  endtask
  initial begin
    bus.din = '0;
    bus.din_valid = 0;
    bus.frame_sync = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    apply(1, 0, 32'h55);
    apply(1, 0, 32'h66);
    frame4(32'h11, 32'h22, 32'h33, 32'h44);
    apply(0, 0, 32'h0);
    apply(1, 1, 32'hAA);
    apply(1, 0, 32'hBB);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 0, 32'h77);
    for (int k = 0; k < 8; k++) begin
      apply(1, k % 4 == 0, k < 4 ? 32'hA0 + k : 32'hB0 + k - 4);
      repeat ($urandom_range(0, 3)) apply(0, 0, $urandom);
    end
    apply(1, 1, 32'h01);
    apply(1, 0, 32'h02);
    frame4(32'h10, 32'h20, 32'h30, 32'h40);
    frame4(32'h11, 32'h22, 32'h33, 32'h44);
    apply(1, 0, 32'h55);
    apply(1, 0, 32'h66);
    apply(1, 0, 32'h77);
    frame4(32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h1);
    apply(0, 0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      bit v, f;
      v = ($urandom % 4) != 0;
      if (!m_lk) f = ($urandom % 3) == 0;
      else if (q.size() == 0) f = ($urandom % 8) != 0;
      else f = ($urandom % 12) == 0;
      apply(v, f, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
